// File: rtl/texture_cache_pkg.sv
// Shared types and helpers for the set-associative texture cache.
package texture_cache_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_MISS_REQ  = 2'd1,
    ST_MISS_WAIT = 2'd2,
    ST_INV       = 2'd3
  } cache_state_e;

  // Lowest-numbered way whose valid bit is clear; 0 when every way is valid.
  // Callers pad unused upper ways with 1 so they are never chosen.
  function automatic logic [2:0] tc_first_invalid(input logic [7:0] valid);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (!valid[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/tex_cache_way_ram.sv
// One cache way: tag and line storage with a single write port and an
// enable-gated synchronous read port.
module tex_cache_way_ram #(
  parameter int DEPTH  = 32,
  parameter int IDX_W  = 5,
  parameter int TAG_W  = 21,
  parameter int LINE_W = 512
) (
  input  logic              clk,
  input  logic              i_rd_en,
  input  logic [IDX_W-1:0]  i_rd_idx,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [TAG_W-1:0]  i_wr_tag,
  input  logic [LINE_W-1:0] i_wr_line,
  output logic [TAG_W-1:0]  o_rd_tag,
  output logic [LINE_W-1:0] o_rd_line
);

  logic [TAG_W-1:0]  r_tag_mem  [DEPTH];
  logic [LINE_W-1:0] r_line_mem [DEPTH];

  // Refill write of tag and line into one set.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag_mem[i_wr_idx]  <= i_wr_tag;
      r_line_mem[i_wr_idx] <= i_wr_line;
    end
  end

  // Registered read, only on request accept so the output holds through a miss.
  always_ff @(posedge clk) begin
    if (i_rd_en) begin
      o_rd_tag  <= r_tag_mem[i_rd_idx];
      o_rd_line <= r_line_mem[i_rd_idx];
    end
  end

endmodule

// File: rtl/texture_cache_sa.sv
// Set-associative texture cache: one word read per cycle on hits, full-line
// refill with bypass on misses, round-robin replacement, invalidate-all.
module texture_cache_sa
  import texture_cache_pkg::*;
#(
  parameter int LINE_BYTES = 64,
  parameter int SETS       = 32,
  parameter int WAYS       = 2,
  parameter int RD_W       = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  input  logic [31:0]             req_addr,
  input  logic [RD_W-1:0]         req_rd,
  output logic                    req_ready,
  output logic                    resp_valid,
  output logic [31:0]             resp_data,
  output logic [RD_W-1:0]         resp_rd,
  output logic                    miss_req_valid,
  output logic [31:0]             miss_req_addr,
  input  logic                    miss_req_ready,
  input  logic                    miss_resp_valid,
  input  logic [LINE_BYTES*8-1:0] miss_resp_data,
  input  logic                    inv_valid,
  output logic                    inv_ready,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count
);

  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = 32 - OFF_W - IDX_W;
  localparam int LINE_W = LINE_BYTES * 8;
  localparam int WORDS  = LINE_BYTES / 4;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  function automatic logic [31:0] sel_word(input logic [LINE_W-1:0] line,
                                           input logic [OFF_W-1:0]  off);
    logic [31:0] word;
    word = '0;
    for (int w = 0; w < WORDS; w++) begin
      if ((32'(off) >> 2) == 32'(w)) word = line[w*32 +: 32];
    end
    return word;
  endfunction

  cache_state_e      r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_inv_cnt;

  logic              r_vld_p2;
  logic [TAG_W-1:0]  r_tag_p2;
  logic [IDX_W-1:0]  r_idx_p2;
  logic [OFF_W-1:0]  r_off_p2;
  logic [RD_W-1:0]   r_rd_p2;

  logic [WAYS-1:0]   r_valid [SETS];
  logic [WAY_W-1:0]  r_ptr   [SETS];

  logic [TAG_W-1:0]  w_ram_tag  [WAYS];
  logic [LINE_W-1:0] w_ram_line [WAYS];

  logic              w_accept, w_hit, w_miss, w_hit_resp, w_fill, w_set_full;
  logic [WAYS-1:0]   w_set_valid, w_hit_vec;
  logic [7:0]        w_valid_pad;
  logic [LINE_W-1:0] w_hit_line;
  logic [WAY_W-1:0]  w_victim, w_ptr_cur, w_ptr_nxt;

  wire [TAG_W-1:0] w_req_tag = req_addr[31:OFF_W+IDX_W];
  wire [IDX_W-1:0] w_req_idx = req_addr[OFF_W+IDX_W-1:OFF_W];
  wire [OFF_W-1:0] w_req_off = req_addr[OFF_W-1:0];

  assign w_accept = req_valid && req_ready;

  // ---- S1: accept edge reads every way at the request index ----
  for (genvar g = 0; g < WAYS; g++) begin : g_way
    tex_cache_way_ram #(
      .DEPTH (SETS),
      .IDX_W (IDX_W),
      .TAG_W (TAG_W),
      .LINE_W(LINE_W)
    ) u_ram (
      .clk      (clk),
      .i_rd_en  (w_accept),
      .i_rd_idx (w_req_idx),
      .i_wr_en  (w_fill && (w_victim == WAY_W'(g))),
      .i_wr_idx (r_idx_p2),
      .i_wr_tag (r_tag_p2),
      .i_wr_line(miss_resp_data),
      .o_rd_tag (w_ram_tag[g]),
      .o_rd_line(w_ram_line[g])
    );
  end

  // S2 occupancy: load on accept, drop once the request has been answered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_vld_p2 <= 1'b0;
    else if (w_accept)             r_vld_p2 <= 1'b1;
    else if (w_hit_resp || w_fill) r_vld_p2 <= 1'b0;
  end

  // S2 request fields; held unchanged for the whole miss sequence.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_tag_p2 <= w_req_tag;
      r_idx_p2 <= w_req_idx;
      r_off_p2 <= w_req_off;
      r_rd_p2  <= req_rd;
    end
  end

  // ---- S2: tag compare across all ways ----
  assign w_set_valid = r_valid[r_idx_p2];

  // Hit detection and hit-way line select.
  always_comb begin
    w_hit_vec  = '0;
    w_hit_line = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (w_set_valid[w] && (w_ram_tag[w] == r_tag_p2)) begin
        w_hit_vec[w] = 1'b1;
        w_hit_line   = w_ram_line[w];
      end
    end
  end

  assign w_hit      = |w_hit_vec;
  assign w_miss     = r_vld_p2 && !w_hit;
  assign w_hit_resp = (r_state == ST_RUN) && r_vld_p2 && w_hit;
  assign w_fill     = (r_state == ST_MISS_WAIT) && miss_resp_valid;

  assign resp_valid = w_hit_resp || w_fill;
  assign resp_data  = w_hit_resp ? sel_word(w_hit_line, r_off_p2) :
                      w_fill     ? sel_word(miss_resp_data, r_off_p2) : '0;
  assign resp_rd    = resp_valid ? r_rd_p2 : '0;

  // Victim: first empty way, else the set's round-robin pointer.
  always_comb begin
    w_valid_pad = '1;
    w_valid_pad[WAYS-1:0] = w_set_valid;
  end

  assign w_set_full = &w_set_valid;
  assign w_ptr_cur  = r_ptr[r_idx_p2];
  assign w_ptr_nxt  = (w_ptr_cur == WAY_W'(WAYS - 1)) ? '0 : w_ptr_cur + 1'b1;
  assign w_victim   = w_set_full ? w_ptr_cur : WAY_W'(tc_first_invalid(w_valid_pad));

  // Valid bits and pointers: cleared set-by-set during invalidate, set on fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_ptr[s]   <= '0;
      end
    end else if (r_state == ST_INV) begin
      r_valid[r_inv_cnt] <= '0;
      r_ptr[r_inv_cnt]   <= '0;
    end else if (w_fill) begin
      r_valid[r_idx_p2][w_victim] <= 1'b1;
      if (w_set_full) r_ptr[r_idx_p2] <= w_ptr_nxt;
    end
  end

  // Invalidate walk counter; sits at 0 outside INV.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_inv_cnt <= '0;
    else if (r_state == ST_INV) r_inv_cnt <= r_inv_cnt + 1'b1;
    else                        r_inv_cnt <= '0;
  end

  // Wrapping performance counters; a miss is counted once, when first seen in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (w_hit_resp)                    hit_count  <= hit_count + 1'b1;
      if (r_state == ST_RUN && w_miss)   miss_count <= miss_count + 1'b1;
    end
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  // Controller next state and handshake outputs.
  always_comb begin
    w_state_nxt    = r_state;
    req_ready      = 1'b0;
    inv_ready      = 1'b0;
    miss_req_valid = 1'b0;
    miss_req_addr  = '0;
    case (r_state)
      ST_RUN: begin
        inv_ready = !r_vld_p2;
        req_ready = !w_miss && !(inv_valid && !r_vld_p2);
        if (inv_valid && !r_vld_p2) w_state_nxt = ST_INV;
        else if (w_miss)            w_state_nxt = ST_MISS_REQ;
      end
      ST_MISS_REQ: begin
        miss_req_valid = 1'b1;
        miss_req_addr  = {r_tag_p2, r_idx_p2, {OFF_W{1'b0}}};
        if (miss_req_ready) w_state_nxt = ST_MISS_WAIT;
      end
      ST_MISS_WAIT: begin
        if (miss_resp_valid) w_state_nxt = ST_RUN;
      end
      ST_INV: begin
        if (r_inv_cnt == IDX_W'(SETS - 1)) w_state_nxt = ST_RUN;
      end
    endcase
    if (!rst_n) begin
      req_ready = 1'b0;
      inv_ready = 1'b0;
    end
  end

endmodule
